// File: rtl/cnn_pkg.sv
// Shared CNN streaming definitions.
//   DataWidth : default element width for the pad/unpad blocks
//   psize()   : padded edge length for an unpadded edge length
//   cnt_width(): counter width for a 0..max-1 counter, never below 1 bit
package cnn_pkg;

  localparam int unsigned DataWidth = 32;

  function automatic int unsigned psize(input int unsigned size);
    return 2 * size - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max);
    return (max > 1) ? $clog2(max) : 1;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column raster counter over a MAX x MAX grid.
//   clk   : clock, rising edge
//   reset : synchronous active-low reset
//   inc   : advance one position
//   row   : current row    (0..MAX-1)
//   col   : current column (0..MAX-1)
//   wrap  : high while inc is applied at the last position (MAX-1, MAX-1)
module raster_counter
  import cnn_pkg::*;
#(
  parameter int unsigned MAX = 9,
  localparam int unsigned CW = cnt_width(MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic          wrap
);

  localparam logic [CW-1:0] LastIdx = CW'(MAX - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_end, row_end;

  assign col_end = (col_q == LastIdx);
  assign row_end = (row_q == LastIdx);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (inc) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign wrap = inc && col_end && row_end;

endmodule

// File: rtl/zero_unpad.sv
// Crops a padded PSIZE x PSIZE raster stream down to its top-left SIZE x SIZE window.
//   clk, reset           : clock and synchronous active-low reset
//   en                   : block enable; no input accepted while low
//   s_valid/s_data/s_ready : padded input stream
//   m_valid/m_data/m_ready : cropped output stream, m_last on element (SIZE-1, SIZE-1)
//   frame_done           : one-cycle pulse after the final padded element is consumed
//   pad_err              : sticky flag, a dropped element carried nonzero data
module zero_unpad
  import cnn_pkg::*;
#(
  parameter int unsigned SIZE = 5,
  parameter int unsigned DW   = DataWidth
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  output logic          m_last,
  output logic          frame_done,
  output logic          pad_err
);

  localparam int unsigned PSIZE = psize(SIZE);
  localparam int unsigned CW    = cnt_width(PSIZE);
  localparam logic [CW-1:0] SizeC = CW'(SIZE);
  localparam logic [CW-1:0] EdgeC = CW'(SIZE - 1);

  logic [CW-1:0] row, col;
  logic          wrap;
  logic          kept;
  logic          in_hs, keep_hs, drop_hs;

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          perr_q, perr_d;

  assign kept = (row < SizeC) && (col < SizeC);

  // Dropped positions never touch the output register, so they need no backpressure.
  always_comb begin
    s_ready = 1'b0;
    if (reset && en) begin
      s_ready = kept ? (!valid_q || m_ready) : 1'b1;
    end
  end

  assign in_hs   = s_valid && s_ready;
  assign keep_hs = in_hs && kept;
  assign drop_hs = in_hs && !kept;

  raster_counter #(
    .MAX (PSIZE)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (in_hs),
    .row   (row),
    .col   (col),
    .wrap  (wrap)
  );

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (keep_hs) begin
      // Reload covers the same-cycle drain case without a bubble.
      valid_d = 1'b1;
      data_d  = s_data;
      last_d  = (row == EdgeC) && (col == EdgeC);
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
    done_d = wrap;
    perr_d = perr_q || (drop_hs && (s_data != '0));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  assign m_valid    = valid_q;
  assign m_data     = data_q;
  assign m_last     = last_q;
  assign frame_done = done_q;
  assign pad_err    = perr_q;

endmodule

// File: tb/tb_zero_unpad.sv
// Randomised/directed bench for zero_unpad (SIZE=5, DW=32) against a frame-position model.
module tb_zero_unpad;

  localparam int S  = 5;
  localparam int P  = 2 * S - 1;
  localparam int PP = P * P;
  localparam int BadPos = 2 * P + 7;

  logic        clk = 1'b0;
  logic        reset, en, s_valid, m_ready;
  logic [31:0] s_data;
  logic        s_ready, m_valid, m_last, frame_done, pad_err;
  logic [31:0] m_data;

  zero_unpad #(
    .SIZE (S),
    .DW   (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .frame_done (frame_done),
    .pad_err    (pad_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position in the padded frame plus a queue of cropped values awaiting output.
  int          idx = 0;
  logic [31:0] q_data[$];
  bit          q_last[$];
  bit          done_exp = 0;
  bit          perr_exp = 0;
  bit          last_in_hs = 0;
  bit          inject_bad = 0;
  int          n_out = 0;
  int          n_done = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_kept(input int i);
    return (i / P < S) && (i % P < S);
  endfunction

  function automatic logic [31:0] data_for(input int i);
    if (inject_bad && i == BadPos) return 32'hDEAD_BEEF;
    return is_kept(i) ? 32'(i + 1) : 32'h0;
  endfunction

  task automatic step(input bit rst, input bit e, input bit sv, input logic [31:0] sd,
                      input bit mr);
    bit exp_ready, exp_valid, out_hs, in_hs;
    @(negedge clk);
    reset = rst; en = e; s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    exp_valid = (q_data.size() > 0);
    exp_ready = rst && e && (!is_kept(idx) || !exp_valid || mr);
    check_eq("s_ready", s_ready, exp_ready);
    check_eq("m_valid", m_valid, exp_valid);
    if (exp_valid) begin
      check_eq("m_data", m_data, q_data[0]);
      check_eq("m_last", m_last, q_last[0]);
    end
    check_eq("frame_done", frame_done, done_exp);
    check_eq("pad_err", pad_err, perr_exp);
    last_in_hs = 0;
    if (!rst) begin
      idx = 0; q_data.delete(); q_last.delete(); done_exp = 0; perr_exp = 0;
    end else begin
      out_hs = exp_valid && mr;
      in_hs  = sv && exp_ready;
      last_in_hs = in_hs;
      done_exp = 0;
      if (out_hs) begin
        void'(q_data.pop_front()); void'(q_last.pop_front()); n_out++;
      end
      if (in_hs) begin
        if (is_kept(idx)) begin
          q_data.push_back(sd);
          q_last.push_back((idx / P == S - 1) && (idx % P == S - 1));
        end else if (sd != 0) begin
          perr_exp = 1;
        end
        if (idx == PP - 1) begin
          done_exp = 1; n_done++;
        end
        idx = (idx + 1) % PP;
      end
    end
    @(posedge clk);
  endtask

  // mode 0: m_ready held high, mode 1: m_ready toggles 1,0,1,0...
  task automatic run_inputs(input int n, input int mode, output int cycles);
    int got = 0;
    cycles = 0;
    while (got < n && cycles < 2000) begin
      step(1, 1, 1, data_for(idx), (mode == 1) ? (cycles % 2 == 0) : 1'b1);
      if (last_in_hs) got++;
      cycles++;
    end
    check_eq("input_budget", got, n);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0, 1);
  endtask

  initial begin
    int cyc, o0, d0;
    logic [31:0] rd;
    reset = 0; en = 0; s_valid = 0; s_data = 0; m_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_m_data", m_data, 32'h0);
    step(0, 1, 1, 32'h0, 1);

    // Basic frame, full throughput.
    o0 = n_out; d0 = n_done;
    run_inputs(PP, 0, cyc);
    check_eq("frame1_cycles", cyc, PP);
    drain();
    check_eq("frame1_outputs", n_out - o0, 25);
    check_eq("frame1_done", n_done - d0, 1);

    // Output stalls every other cycle.
    o0 = n_out;
    run_inputs(PP, 1, cyc);
    drain();
    check_eq("toggle_outputs", n_out - o0, 25);

    // Back-to-back frames, no idle cycles.
    o0 = n_out; d0 = n_done;
    run_inputs(2 * PP, 0, cyc);
    check_eq("b2b_cycles", cyc, 2 * PP);
    drain();
    check_eq("b2b_outputs", n_out - o0, 50);
    check_eq("b2b_done", n_done - d0, 2);

    // Enable gap after input 12.
    o0 = n_out;
    run_inputs(12, 0, cyc);
    for (int i = 0; i < 5; i++) step(1, 0, 1, data_for(idx), 1);
    run_inputs(PP - 12, 0, cyc);
    drain();
    check_eq("en_gap_outputs", n_out - o0, 25);

    // Nonzero pad at (2,7).
    inject_bad = 1;
    o0 = n_out;
    run_inputs(PP, 0, cyc);
    inject_bad = 0;
    drain();
    check_eq("pad_outputs", n_out - o0, 25);
    check_eq("pad_err_sticky", pad_err, 1'b1);

    // Reset mid-frame after input 40.
    run_inputs(40, 0, cyc);
    step(0, 1, 1, data_for(idx), 1);
    #1;
    check_eq("midreset_m_data", m_data, 32'h0);
    o0 = n_out; d0 = n_done;
    run_inputs(PP, 0, cyc);
    drain();
    check_eq("post_reset_outputs", n_out - o0, 25);
    check_eq("post_reset_done", n_done - d0, 1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if (is_kept(idx)) rd = $urandom;
      else rd = ($urandom_range(15) == 0) ? ($urandom | 32'h1) : 32'h0;
      step($urandom_range(299) != 0, $urandom_range(7) != 0, $urandom_range(3) != 0, rd,
           $urandom_range(2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zero_unpad.md
ZERO_UNPAD -- requirements
Module: zero_unpad

Interface
REQ-001 Parameter SIZE, default 5, unpadded feature-map edge length; padded edge PSIZE = 2*SIZE-1.
REQ-002 Parameter DW, default 32, element width in bits.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 en  input  1  block enable; when 0, no input is accepted.
REQ-006 s_valid  input  1  padded-stream element valid.
REQ-007 s_data  input  DW  padded-stream element, raster order (row-major, row 0 col 0 first).
REQ-008 s_ready  output  1  element accepted when s_valid && s_ready.
REQ-009 m_valid  output  1  cropped-stream element valid.
REQ-010 m_data  output  DW  cropped-stream element.
REQ-011 m_ready  input  1  downstream accepts when m_valid && m_ready.
REQ-012 m_last  output  1  qualifies m_data as cropped element (SIZE-1,SIZE-1).
REQ-013 frame_done  output  1  one-cycle pulse, full PSIZE x PSIZE frame consumed.
REQ-014 pad_err  output  1  sticky; a dropped (pad) element was nonzero.

Function
REQ-015 Input counters row,col (0..PSIZE-1) SHALL advance on each input handshake: col+1; at col=PSIZE-1, col->0 and row+1; at (PSIZE-1,PSIZE-1), both ->0.
REQ-016 Element at (row,col) is "kept" iff row<SIZE and col<SIZE; otherwise "dropped".
REQ-017 s_ready SHALL be 0 when en=0; else 1 for a dropped position; else (!m_valid || m_ready) for a kept position.
REQ-018 Kept accepted element SHALL appear on m_data with m_valid=1 the cycle after acceptance (latency 1).
REQ-019 m_valid/m_data/m_last SHALL hold stable while m_valid && !m_ready.
REQ-020 Same-cycle output handshake and kept input acceptance: register reloads, m_valid stays 1, no bubble.
REQ-021 Output handshake without new kept input: m_valid -> 0.
REQ-022 m_last SHALL be 1 exactly for output of kept element (SIZE-1,SIZE-1), i.e. every SIZE*SIZE-th output.
REQ-023 Dropped elements SHALL never reach m_data; if s_data != 0 on a dropped handshake, pad_err -> 1 next cycle and stays 1 until reset.
REQ-024 frame_done SHALL pulse 1 for one cycle, the cycle after handshake of (PSIZE-1,PSIZE-1); counters wrap for the next frame with no idle cycle.
REQ-025 en=0 mid-frame: counters freeze, pending m_valid output still drains on m_ready; resumes at same position when en=1.
REQ-026 Output ordering SHALL be raster order of the kept SIZE x SIZE window.

Reset
REQ-027 With reset=0 at a clk edge: row=col=0, m_valid=0, m_data=0, m_last=0, frame_done=0, pad_err=0.
REQ-028 s_ready SHALL be 0 while reset=0.
REQ-029 Reset mid-frame SHALL discard the partial frame and pending output; next accepted element is (0,0).

Structure
REQ-030 DW default and function psize(SIZE)=2*SIZE-1 SHALL live in shared package cnn_pkg, also used by zero_pad.
REQ-031 Row/column wrap counter SHALL be sub-module raster_counter (params MAX; ports clk, reset, inc, row, col, wrap).
REQ-032 Counter widths SHALL be $clog2(PSIZE); no other parameter-dependent widths.

Verification
REQ-033 SIZE=5, s_valid=1, m_ready=1, inputs 1..81 with pads 0 -> 25 outputs = row-major 5x5 top-left window, m_last on 25th, frame_done once, pad_err=0.
REQ-034 m_ready toggled 1010... during kept region -> no loss/duplication, data held stable while stalled.
REQ-035 Dropped position (2,7) carries 0xDEAD_BEEF -> not output, pad_err=1 from next cycle through end of test.
REQ-036 Two back-to-back frames, s_valid=1 continuous -> frame_done pulses after input 81 and 162, 50 outputs, zero idle cycles between frames.
REQ-037 reset=0 for one cycle after input 40 -> m_valid=0, next input treated as (0,0), following full frame cropped correctly.
REQ-038 en=0 for 5 cycles at input 12 -> s_ready=0, counters held, pending output drains; output sequence unchanged vs. REQ-033.
